cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single off-chip main-memory port between the I-cache and D-cache miss/write-back engines of the pipelined MIPS core.
- Grants one block transfer at a time and registers the winner's command onto the memory bus.
- Returns the memory's data and completion pulse to the granted cache only.
- Sits between the two cache controllers and the memory model/slave at top level.

Parameters:
- ADDR_W, 28, block address width (word address minus 2-bit block offset).
- DATA_W, 128, block width (4 words).
- STARVE_LIMIT, 4, consecutive D grants tolerated while I is pending before I is forced (fixed-priority mode only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache block read request; held until i_ready
- i_addr  in  ADDR_W  I-cache block address
- i_rdata  out  DATA_W  read data to I-cache
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache block read request; held until d_ready
- d_write  in  1  D-cache block write-back request; held until d_ready
- d_addr  in  ADDR_W  D-cache block address
- d_wdata  in  DATA_W  D-cache write-back data
- d_rdata  out  DATA_W  read data to D-cache
- d_ready  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read command, registered
- mem_write  out  1  memory write command, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion pulse
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0.
  - last_grant = I.
  - starve_cnt = 0.
- States:
  - IDLE: no grant. Requests are sampled here.
  - GNT_I: I transfer in flight.
  - GNT_D: D transfer in flight.
- IDLE, no request: stay in IDLE.
- IDLE, only I pending: -> GNT_I.
- IDLE, only D pending: -> GNT_D.
- IDLE, both pending (fixed-priority mode): grant D, unless starve_cnt == STARVE_LIMIT, in which case grant I.
- Starvation counter:
  - Increments on each D grant while i_read is high.
  - Clears on any I grant and whenever i_read is low in IDLE.
  - Saturates at STARVE_LIMIT.
- Actions on the grant edge:
  - Latch the winner's command into the mem_* registers, so mem_read/mem_write are high from the first cycle of GNT_*.
  - D with both d_read and d_write high: issue the write (write-back before allocate). The D-cache then re-requests the read.
- GNT_x, waiting: mem_* are held constant until mem_ready.
- GNT_x, completion cycle (mem_ready = 1):
  - Drive x_ready = 1 combinationally.
  - For a read, drive x_rdata = mem_rdata in the same cycle.
  - Clear mem_read/mem_write at the clock edge and -> IDLE.
- Completion latency: x_ready appears 0 cycles after mem_ready. Minimum grant-to-ready is 1 cycle plus memory latency.
- Back-to-back grants: after returning to IDLE, the next grant is evaluated from the requests in that IDLE cycle. A cache that drops its request on the edge after x_ready is therefore never re-granted. Minimum gap is 1 IDLE cycle.
- Ungranted cache sees x_ready = 0 and x_rdata = 0.
- Requester dropping its request mid-transfer: illegal. The arbiter still completes the memory transaction and pulses x_ready.
- mem_ready arriving in IDLE: ignored, no ready pulse.
- Reset asserted mid-transfer: immediate return to IDLE and all outputs 0. The memory side must tolerate an abandoned command.
- No arithmetic beyond the saturating starvation counter, which is $clog2(STARVE_LIMIT+1) bits wide.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - When both caches are pending, grant the opposite of last_grant.
  - last_grant updates on every grant.
  - starve_cnt and STARVE_LIMIT are unused (counter not synthesized).
- Undefined: D-priority with starvation limit, as described in Behaviour.
- Single-requester behaviour is identical in both modes.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2.
  - Requester ID constants: REQ_I = 1'b0, REQ_D = 1'b1.
  - Defaults for ADDR_W and DATA_W, also used by both cache controllers.
- One natural sub-module: arb_pick.
  - Combinational winner selection from i_read, d_read|d_write, last_grant and starve_cnt.
  - Holds the only macro-dependent logic.
- The FSM and mem_* registers stay in the top module.

Test Plan:
- Single I read: i_read = 1, i_addr = 28'h0000040; memory returns mem_ready after 3 cycles with rdata 128'hA5..A5. Expect mem_read high for exactly the 4 GNT_I cycles, i_ready for 1 cycle with i_rdata = A5..A5, and d_ready = 0 throughout.
- D read+write together: d_read = d_write = 1, d_addr = 28'h10, d_wdata = 128'h1234. Expect mem_write = 1, mem_read = 0, mem_wdata = 128'h1234. After d_ready, the D-cache holds only d_read, and the next grant is a read of addr 28'h10.
- Fixed-priority starvation (STARVE_LIMIT = 4): i_read held high while D issues 6 back-to-back requests. Expect grant order D, D, D, D, I, D, D. Under ARB_ROUND_ROBIN_EN, expect D, I, D, I ...
- Simultaneous first request after reset: both pending, last_grant = I. Expect D granted first in both modes.
- Reset mid-transfer: assert rst 2 cycles into GNT_D. Expect mem_write = 0, busy = 0 and d_ready = 0 immediately, and no ready pulse when a stray mem_ready arrives afterwards.
- Spurious mem_ready in IDLE: expect no i_ready/d_ready and state stays IDLE.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache-to-main-memory arbiter and the cache
// controllers that sit on either side of it.
package cache_mem_arbiter_pkg;

  // Block address and block data widths shared with both cache controllers.
  localparam int ADDR_W_DEF       = 28;
  localparam int DATA_W_DEF       = 128;
  localparam int STARVE_LIMIT_DEF = 4;

  // Arbiter states: idle, or a block transfer owned by one cache.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  // Requester identities, used for the grant decision and last_grant.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Width of a saturating counter that must be able to hold 0..limit.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_arb_pick.sv
// Winner selection between the I-cache and D-cache requests.
// Default build: D has priority, but I is forced once the starvation
// counter reaches STARVE_LIMIT. With ARB_ROUND_ROBIN_EN defined, a tie
// goes to whichever cache did not win last time.
// A lone requester always wins in either mode.
module arb_pick
  import cache_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = cnt_width(STARVE_LIMIT)
) (
  input  logic             i_req,
  input  logic             d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic             last_grant,
`else
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             grant_valid,
  output logic             grant_id
);

`ifndef ARB_ROUND_ROBIN_EN
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);
`endif

  // Pick a winner whenever at least one cache is requesting.
  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = REQ_I;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
`else
      grant_id = (starve_cnt == LIMIT_CNT) ? REQ_I : REQ_D;
`endif
    end else if (d_req) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single main-memory port between the I-cache and D-cache.
// One block transfer is granted at a time; the winner's command is
// registered onto the memory bus, and the memory's completion pulse and
// read data are routed back to the granted cache only.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie-break
// instead of D priority with a starvation limit).
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);

  arb_state_t state;
  logic       d_req;
  logic       grant_valid;
  logic       grant_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
`else
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt;
`endif

  assign d_req = d_read | d_write;
  assign busy  = (state != IDLE);

  arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .i_req       (i_read),
    .d_req       (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant),
`else
    .starve_cnt  (starve_cnt),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Grant FSM: latch the winner's command on the grant edge, hold it until
  // memory completes, then drop the command and return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            if (grant_id == REQ_I) begin
              state     <= GNT_I;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end else begin
              // A write-back always goes first; the D-cache re-requests
              // the allocate read afterwards.
              state     <= GNT_D;
              mem_read  <= ~d_write;
              mem_write <= d_write;
              mem_addr  <= d_addr;
              mem_wdata <= d_write ? d_wdata : '0;
            end
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who won the most recent grant for the round-robin tie-break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_I;
    end else if (state == IDLE && grant_valid) begin
      last_grant <= grant_id;
    end
  end
`else
  // Count D grants that overtook a waiting I request, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!i_read || (grant_valid && grant_id == REQ_I)) begin
        starve_cnt <= '0;
      end else if (grant_valid && grant_id == REQ_D && starve_cnt != LIMIT_CNT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`endif

  // Route the completion pulse and read data to the owning cache only.
  always_comb begin
    i_ready = (state == GNT_I) && mem_ready;
    d_ready = (state == GNT_D) && mem_ready;
    i_rdata = i_ready ? mem_rdata : '0;
    d_rdata = (d_ready && mem_read) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
// Honors ARB_ROUND_ROBIN_EN the same way the design does.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int AW    = 28;
  localparam int DW    = 128;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;

  cache_mem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: who owns the memory port and what command is on it.
  int            m_owner;     // 0 none, 1 I-cache, 2 D-cache
  bit            m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_starve;
  int            m_last;      // 1 I-cache, 2 D-cache
  int            m_elapsed;

  // Stimulus knobs and requester bookkeeping.
  bit            auto_req;
  int            i_rate, d_rate, i_keep, d_keep, spur_rate, lat_max, lat_fixed, cur_lat;
  bit            use_fixed_rdata;
  logic [DW-1:0] rdata_fixed;
  bit            i_done, d_done, prev_busy;

  // Observations of the DUT for scenario-level checks.
  int            grants[$];
  logic [1:0]    grant_ops[$];
  logic [AW-1:0] grant_addrs[$];
  int            obs_mem_read, obs_i_ready, obs_d_ready;

  int exp_order[7];

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  task automatic modelReset();
    m_owner   = 0;
    m_rd      = 0;
    m_wr      = 0;
    m_addr    = '0;
    m_wdata   = '0;
    m_starve  = 0;
    m_last    = 1;
    m_elapsed = 0;
  endtask

  task automatic newDRequest();
    int k;
    k       = int'($urandom_range(2, 0));
    d_read  = (k != 1);
    d_write = (k != 0);
    d_addr  = {1'b1, (AW-1)'($urandom)};
    d_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Drive memory responses and, in auto mode, both cache requesters.
  task automatic applyStimulus();
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    mem_ready = 1'b0;
    if (m_owner != 0) begin
      if (m_elapsed == 0)
        cur_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(lat_max, 0));
      if (m_elapsed == cur_lat) begin
        mem_ready = 1'b1;
        if (use_fixed_rdata) mem_rdata = rdata_fixed;
      end
    end else if (roll(spur_rate)) begin
      mem_ready = 1'b1;
    end
    if (auto_req) begin
      if (i_read) begin
        if (i_done) begin
          if (roll(i_keep)) i_addr = {1'b0, (AW-1)'($urandom)};
          else i_read = 1'b0;
        end
      end else if (roll(i_rate)) begin
        i_read = 1'b1;
        i_addr = {1'b0, (AW-1)'($urandom)};
      end
      if (d_read || d_write) begin
        if (d_done) begin
          if (d_read && d_write) d_write = 1'b0;
          else if (roll(d_keep)) newDRequest();
          else begin
            d_read  = 1'b0;
            d_write = 1'b0;
          end
        end
      end else if (roll(d_rate)) begin
        newDRequest();
      end
    end
  endtask

  // Check one cycle against the model, then advance the model past the edge.
  task automatic evalCycle();
    bit            exp_i_ready, exp_d_ready, ireq, dreq;
    logic [DW-1:0] exp_i_rdata, exp_d_rdata;
    int            win;
    #1;
    exp_i_ready = (m_owner == 1) && mem_ready;
    exp_d_ready = (m_owner == 2) && mem_ready;
    exp_i_rdata = exp_i_ready ? mem_rdata : '0;
    exp_d_rdata = (exp_d_ready && m_rd) ? mem_rdata : '0;
    checkOutput("busy", busy, m_owner != 0);
    checkOutput("mem_read", mem_read, m_rd);
    checkOutput("mem_write", mem_write, m_wr);
    if (m_rd || m_wr) checkOutput("mem_addr", mem_addr, m_addr);
    if (m_wr) checkOutput("mem_wdata", mem_wdata, m_wdata);
    checkOutput("i_ready", i_ready, exp_i_ready);
    checkOutput("i_rdata", i_rdata, exp_i_rdata);
    checkOutput("d_ready", d_ready, exp_d_ready);
    checkOutput("d_rdata", d_rdata, exp_d_rdata);
    if (busy && !prev_busy) begin
      grants.push_back(mem_addr[AW-1] ? 2 : 1);
      grant_ops.push_back({mem_write, mem_read});
      grant_addrs.push_back(mem_addr);
    end
    prev_busy    = busy;
    obs_mem_read += int'(mem_read);
    obs_i_ready  += int'(i_ready);
    obs_d_ready  += int'(d_ready);
    i_done = exp_i_ready;
    d_done = exp_d_ready;

    if (m_owner == 0) begin
      ireq = i_read;
      dreq = d_read || d_write;
      win  = 0;
      if (ireq && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = (m_last == 1) ? 2 : 1;
`else
        win = (m_starve >= LIMIT) ? 1 : 2;
`endif
      end else if (ireq) win = 1;
      else if (dreq) win = 2;
`ifdef ARB_ROUND_ROBIN_EN
      if (win != 0) m_last = win;
`else
      if (!ireq || win == 1) m_starve = 0;
      else if (win == 2 && m_starve < LIMIT) m_starve++;
`endif
      if (win == 1) begin
        m_rd   = 1;
        m_wr   = 0;
        m_addr = i_addr;
      end else if (win == 2) begin
        m_rd    = !d_write;
        m_wr    = d_write;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end
      m_owner   = win;
      m_elapsed = 0;
    end else if (mem_ready) begin
      m_owner = 0;
      m_rd    = 0;
      m_wr    = 0;
    end else begin
      m_elapsed++;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst       = 1'b1;
    i_read    = 1'b0;
    i_addr    = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    modelReset();
    i_done    = 0;
    d_done    = 0;
    prev_busy = 0;
    grants.delete();
    grant_ops.delete();
    grant_addrs.delete();
    obs_mem_read = 0;
    obs_i_ready  = 0;
    obs_d_ready  = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_mem_read", mem_read, 0);
    checkOutput("reset_mem_write", mem_write, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_mem_wdata", mem_wdata, 0);
    checkOutput("reset_i_ready", i_ready, 0);
    checkOutput("reset_d_ready", d_ready, 0);
    rst = 1'b0;
  endtask

  // Hard stop in case anything stalls the main sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{2, 1, 2, 1, 2, 1, 2};
`else
    exp_order = '{2, 2, 2, 2, 1, 2, 2};
`endif
    auto_req        = 0;
    i_rate          = 0;
    d_rate          = 0;
    i_keep          = 0;
    d_keep          = 0;
    spur_rate       = 0;
    lat_max         = 3;
    lat_fixed       = -1;
    cur_lat         = 0;
    use_fixed_rdata = 0;
    rdata_fixed     = '0;

    // Single I-cache read with a three-cycle memory.
    $display("[TB] single I read");
    doReset();
    lat_fixed       = 3;
    use_fixed_rdata = 1;
    rdata_fixed     = {16{8'hA5}};
    i_read          = 1'b1;
    i_addr          = 28'h0000040;
    for (int c = 0; c < 10; c++) begin
      if (i_done) i_read = 1'b0;
      applyStimulus();
      evalCycle();
    end
    checkOutput("single_i_mem_read_cycles", obs_mem_read, 4);
    checkOutput("single_i_ready_pulses", obs_i_ready, 1);
    checkOutput("single_i_d_ready_pulses", obs_d_ready, 0);
    use_fixed_rdata = 0;

    // D-cache write-back and allocate read requested together.
    $display("[TB] D read+write");
    doReset();
    lat_fixed = 2;
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_addr    = 28'h10;
    d_wdata   = 128'h1234;
    for (int c = 0; c < 12; c++) begin
      if (d_done) begin
        if (d_write) d_write = 1'b0;
        else d_read = 1'b0;
      end
      applyStimulus();
      evalCycle();
    end
    checkOutput("rw_grant_count", grant_ops.size(), 2);
    checkOutput("rw_first_op", (grant_ops.size() > 0) ? grant_ops[0] : 2'b00, 2'b10);
    checkOutput("rw_second_op", (grant_ops.size() > 1) ? grant_ops[1] : 2'b00, 2'b01);
    checkOutput("rw_second_addr", (grant_addrs.size() > 1) ? grant_addrs[1] : '0, 28'h10);
    checkOutput("rw_d_ready_pulses", obs_d_ready, 2);

    // Both caches continuously requesting right after reset.
    $display("[TB] starvation / tie-break order");
    doReset();
    auto_req  = 1;
    i_rate    = 100;
    d_rate    = 100;
    i_keep    = 100;
    d_keep    = 100;
    lat_fixed = -1;
    lat_max   = 2;
    for (int c = 0; c < 300 && grants.size() < 7; c++) begin
      applyStimulus();
      evalCycle();
    end
    checkOutput("starve_grants_seen", grants.size() >= 7, 1);
    for (int k = 0; k < 7; k++)
      checkOutput($sformatf("grant_order_%0d", k), (k < grants.size()) ? grants[k] : 0, exp_order[k]);
    auto_req = 0;

    // Reset asserted two cycles into a D write, then stray mem_ready.
    $display("[TB] reset mid-transfer");
    doReset();
    lat_fixed = 10;
    d_write   = 1'b1;
    d_addr    = 28'h10;
    d_wdata   = 128'hBEEF;
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      evalCycle();
    end
    rst       = 1'b1;
    mem_ready = 1'b0;
    #1;
    checkOutput("midreset_mem_write", mem_write, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_d_ready", d_ready, 0);
    d_write = 1'b0;
    modelReset();
    i_done    = 0;
    d_done    = 0;
    prev_busy = 0;
    @(negedge clk);
    rst = 1'b0;
    obs_i_ready = 0;
    obs_d_ready = 0;
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1'b1;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      evalCycle();
    end
    checkOutput("stray_ready_pulses", obs_i_ready + obs_d_ready, 0);
    mem_ready = 1'b0;

    // Randomized traffic with spurious memory pulses in IDLE.
    $display("[TB] random traffic");
    doReset();
    auto_req  = 1;
    i_rate    = 40;
    d_rate    = 50;
    i_keep    = 30;
    d_keep    = 30;
    spur_rate = 10;
    lat_fixed = -1;
    lat_max   = 4;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      evalCycle();
    end
    checkOutput("random_grants_seen", grants.size() > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
